// File: rtl/rs_hang_sched.sv
// Round-robin scheduler that grants one link hang window at a time. Windows are
// gated by a start tick, followed by a cooldown, and limited by an optional budget.
module rs_hang_sched #(
   parameter int NPORT = 5,
   parameter int CNT_W = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   cfg_en_i,
   input  logic [31:0]            cfg_tick_begin_i,
   input  logic [CNT_W-1:0]       cfg_cooldown_i,
   input  logic [15:0]            cfg_max_hangs_i,
   input  logic [NPORT-1:0]       req_i,
   input  logic [NPORT*CNT_W-1:0] len_i,
   output logic [NPORT-1:0]       gnt_o,
   output logic [NPORT-1:0]       hang_o,
   output logic                   done_o,
   output logic [15:0]            hangs_cnt_o,
   output logic                   busy_o
);
   localparam int PW = $clog2(NPORT);
   localparam logic [NPORT-1:0] ONE_HOT0 = NPORT'(1);

   typedef enum logic [2:0] {S_WAIT, S_IDLE, S_GRANT, S_HANG, S_COOL, S_EXH} state_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t            state, state_nxt;
   logic [31:0]       cyc;
   logic [PW-1:0]     rr_ptr;
   logic [15:0]       hangs;
   logic              done;
   logic [PW-1:0]     win_port;
   logic [CNT_W-1:0]  cnt;

   logic              win_end, sel_load, cool_load, cnt_dec;
   logic              sel_found;
   logic [PW-1:0]     sel_port;
   logic [CNT_W-1:0]  sel_len;
   logic [CNT_W-1:0]  len_arr [NPORT];
   logic [15:0]       hangs_inc;
   logic              budget_hit;

   for (genvar p = 0; p < NPORT; p++) begin : g_len
      assign len_arr[p] = len_i[p*CNT_W +: CNT_W];
   end

   // First requester at or after rr_ptr, wrapping around the port list.
   always_comb begin : sel_blk
      logic [PW:0] idx;
      idx       = '0;
      sel_found = 1'b0;
      sel_port  = '0;
      for (int i = 0; i < NPORT; i++) begin
         idx = {1'b0, rr_ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(NPORT)) idx = idx - (PW+1)'(NPORT);
         if (!sel_found && req_i[idx[PW-1:0]]) begin
            sel_found = 1'b1;
            sel_port  = idx[PW-1:0];
         end
      end
   end

   assign sel_len    = len_arr[sel_port];
   assign hangs_inc  = sat_inc16(hangs);
   assign budget_hit = (cfg_max_hangs_i != 16'd0) && (hangs_inc >= cfg_max_hangs_i);

   always_comb begin
      state_nxt = state;
      win_end   = 1'b0;
      sel_load  = 1'b0;
      cool_load = 1'b0;
      cnt_dec   = 1'b0;
      case (state)
         S_WAIT: if (cfg_en_i && (cyc >= cfg_tick_begin_i)) state_nxt = S_IDLE;
         S_IDLE: begin
            if (cfg_en_i && sel_found) begin
               state_nxt = S_GRANT;
               sel_load  = 1'b1;
            end
         end
         S_GRANT: begin
            state_nxt = S_HANG;
            if (!cfg_en_i) begin
               state_nxt = S_IDLE;
               win_end   = 1'b1;
            end
         end
         S_HANG: begin
            cnt_dec = 1'b1;
            if (!cfg_en_i) begin
               state_nxt = S_IDLE;
               win_end   = 1'b1;
            end else if (cnt == CNT_W'(1)) begin
               win_end = 1'b1;
               // An abort never enters cooldown or checks the budget; only a full window does.
               if (budget_hit) begin
                  state_nxt = S_EXH;
               end else if (cfg_cooldown_i == '0) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_COOL;
                  cool_load = 1'b1;
               end
            end
         end
         S_COOL: begin
            cnt_dec = 1'b1;
            if (!cfg_en_i || (cnt <= CNT_W'(1))) state_nxt = S_IDLE;
         end
         S_EXH:   state_nxt = S_EXH;
         default: state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= S_WAIT;
         cyc    <= '0;
         rr_ptr <= '0;
         hangs  <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         cyc   <= sat_inc32(cyc);
         done  <= win_end;
         if (win_end) begin
            hangs  <= hangs_inc;
            rr_ptr <= (win_port == PW'(NPORT-1)) ? '0 : win_port + PW'(1);
         end
      end
   end

   // Window port and the shared hang/cooldown counter are only read under state qualification.
   always_ff @(posedge clk_i) begin
      if (sel_load) begin
         win_port <= sel_port;
         cnt      <= (sel_len == '0) ? CNT_W'(1) : sel_len;
      end else if (cool_load) begin
         cnt <= cfg_cooldown_i;
      end else if (cnt_dec) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign gnt_o       = (state == S_GRANT) ? (ONE_HOT0 << win_port) : '0;
   assign hang_o      = (state == S_HANG)  ? (ONE_HOT0 << win_port) : '0;
   assign done_o      = done;
   assign hangs_cnt_o = hangs;
   assign busy_o      = (state == S_GRANT) || (state == S_HANG) || (state == S_COOL);

endmodule

// File: tb/tb_rs_hang_sched.sv
// Bench for rs_hang_sched: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural window model.
module tb_rs_hang_sched;
   localparam int NPORT = 5;
   localparam int CNT_W = 16;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b1;
   logic                   en = 1'b0;
   logic [31:0]            tick = '0;
   logic [CNT_W-1:0]       cool = '0;
   logic [15:0]            maxh = '0;
   logic [NPORT-1:0]       req = '0;
   logic [NPORT*CNT_W-1:0] len_v = '0;
   logic [NPORT-1:0]       gnt, hang;
   logic                   done, busy;
   logic [15:0]            hcnt;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   rs_hang_sched #(.NPORT(NPORT), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .cfg_en_i(en), .cfg_tick_begin_i(tick),
      .cfg_cooldown_i(cool), .cfg_max_hangs_i(maxh), .req_i(req), .len_i(len_v),
      .gnt_o(gnt), .hang_o(hang), .done_o(done), .hangs_cnt_o(hcnt), .busy_o(busy)
   );

   // Behavioural model: a window is "grant pending", then a number of hang
   // cycles left, then a number of cooldown cycles left.
   bit     m_open, m_gnt, m_exh, m_done;
   int     m_port, m_len, m_hang, m_cool, m_rr, m_cnt;
   longint m_cyc;

   task automatic model_reset();
      m_open = 0; m_gnt = 0; m_exh = 0; m_done = 0;
      m_port = 0; m_len = 0; m_hang = 0; m_cool = 0; m_rr = 0; m_cnt = 0;
      m_cyc = 0;
   endtask

   task automatic end_window(input bit normal);
      if (m_cnt < 65535) m_cnt++;
      m_rr   = (m_port + 1) % NPORT;
      m_done = 1;
      if (normal) begin
         if (maxh != 0 && m_cnt >= int'(maxh)) m_exh = 1;
         else m_cool = int'(cool);
      end
   endtask

   task automatic model_step();
      bit found;
      m_done = 0;
      if (m_exh) begin
      end else if (!m_open) begin
         if (en && m_cyc >= longint'(tick)) m_open = 1;
      end else if (m_gnt) begin
         m_gnt = 0;
         if (!en) end_window(0);
         else m_hang = m_len;
      end else if (m_hang > 0) begin
         if (!en) begin m_hang = 0; end_window(0); end
         else if (m_hang == 1) begin m_hang = 0; end_window(1); end
         else m_hang--;
      end else if (m_cool > 0) begin
         if (!en) m_cool = 0;
         else m_cool--;
      end else if (en && req != 0) begin
         found = 0;
         for (int i = 0; i < NPORT; i++) begin
            int p;
            p = (m_rr + i) % NPORT;
            if (!found && req[p]) begin found = 1; m_port = p; end
         end
         m_len = int'(len_v[m_port*CNT_W +: CNT_W]);
         if (m_len == 0) m_len = 1;
         m_gnt = 1;
      end
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
   endtask

   always @(posedge clk) if (rst_n) model_step();

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
      end
   endtask

   // Monitor state used by the directed scenarios.
   int mon_gnt_n, mon_hang_n, mon_done_n, mon_busy_n;
   longint first_gnt_cyc, last_hang_cyc, done_cyc;
   logic [NPORT-1:0] first_gnt_val;
   longint gq_cyc[$];
   int     gq_port[$];

   task automatic clear_mon();
      mon_gnt_n = 0; mon_hang_n = 0; mon_done_n = 0; mon_busy_n = 0;
      first_gnt_cyc = -1; last_hang_cyc = -1; done_cyc = -1; first_gnt_val = '0;
      gq_cyc.delete(); gq_port.delete();
   endtask

   function automatic int oh2idx(input logic [NPORT-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NPORT; i++) if (v[i]) r = i;
      return r;
   endfunction

   always @(negedge clk) begin
      logic [NPORT-1:0] eg, eh;
      eg = m_gnt ? (NPORT'(1) << m_port) : '0;
      eh = (m_hang > 0) ? (NPORT'(1) << m_port) : '0;
      if (chk_on) begin
         check("gnt_o", 32'(gnt), 32'(eg));
         check("hang_o", 32'(hang), 32'(eh));
         check("done_o", 32'(done), 32'(m_done));
         check("hangs_cnt_o", 32'(hcnt), 32'(m_cnt));
         check("busy_o", 32'(busy), 32'(m_gnt || m_hang > 0 || m_cool > 0));
      end
      if (gnt != 0) begin
         mon_gnt_n++;
         if (first_gnt_cyc < 0) begin first_gnt_cyc = m_cyc; first_gnt_val = gnt; end
         gq_cyc.push_back(m_cyc);
         gq_port.push_back(oh2idx(gnt));
      end
      if (hang != 0) begin mon_hang_n++; last_hang_cyc = m_cyc; end
      if (done) begin mon_done_n++; done_cyc = m_cyc; end
      if (busy) mon_busy_n++;
   end

   task automatic step(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      step(3);
      rst_n = 1'b1;
   endtask

   task automatic set_len_all(input int l);
      for (int p = 0; p < NPORT; p++) len_v[p*CNT_W +: CNT_W] = CNT_W'(l);
   endtask

   task automatic wait_gnt(input string name, input int lim);
      bit ok;
      ok = 0;
      for (int k = 0; k < lim && !ok; k++) begin
         step(1);
         if (gnt != 0) ok = 1;
      end
      if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic cfg(input bit e, input int tb, input int c, input int mx, input int l);
      en = e; tick = 32'(tb); cool = CNT_W'(c); maxh = 16'(mx); set_len_all(l);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      model_reset();
      clear_mon();
      chk_on = 1'b1;
      step(2);
      check("reset_gnt", 32'(gnt), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_hcnt", 32'(hcnt), 32'd0);

      // Basic window: port 2, length 4.
      cfg(1, 0, 0, 0, 4); req = '0;
      do_reset(); clear_mon();
      req = 5'b00100;
      wait_gnt("basic", 20);
      req = '0;
      step(10);
      check("basic_gnt_count", 32'(mon_gnt_n), 32'd1);
      check("basic_gnt_val", 32'(first_gnt_val), 32'b00100);
      check("basic_hang_cycles", 32'(mon_hang_n), 32'd4);
      check("basic_done_count", 32'(mon_done_n), 32'd1);
      check("basic_done_after_hang", 32'(done_cyc - last_hang_cyc), 32'd1);
      check("basic_hcnt", 32'(hcnt), 32'd1);

      // Round-robin order and spacing.
      cfg(1, 0, 3, 0, 2); req = '0;
      do_reset(); clear_mon();
      req = 5'b10011;
      step(40);
      req = '0;
      check("rr_enough_grants", 32'(gq_port.size() >= 4), 32'd1);
      if (gq_port.size() >= 4) begin
         check("rr_order0", 32'(gq_port[0]), 32'd0);
         check("rr_order1", 32'(gq_port[1]), 32'd1);
         check("rr_order2", 32'(gq_port[2]), 32'd4);
         check("rr_order3", 32'(gq_port[3]), 32'd0);
         for (int i = 1; i < 4; i++) check("rr_gap", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'd7);
      end

      // Start tick with zero length.
      cfg(1, 100, 0, 0, 0); req = '0;
      do_reset(); clear_mon();
      while (m_cyc < 5) step(1);
      req = 5'b00010;
      wait_gnt("tick", 200);
      req = '0;
      step(5);
      check("tick_first_gnt", 32'(first_gnt_cyc), 32'd102);
      check("tick_hang_cycles", 32'(mon_hang_n), 32'd1);

      // Budget exhaustion.
      cfg(1, 0, 1, 2, 3); req = '0;
      do_reset(); clear_mon();
      req = '1;
      step(40);
      check("budget_hcnt", 32'(hcnt), 32'd2);
      check("budget_grants", 32'(mon_gnt_n), 32'd2);
      clear_mon();
      step(1000);
      check("budget_no_grant", 32'(mon_gnt_n), 32'd0);
      check("budget_no_busy", 32'(mon_busy_n), 32'd0);
      req = '0;

      // Abort by dropping enable on hang cycle 10.
      cfg(1, 0, 0, 0, 50); req = '0;
      do_reset(); clear_mon();
      req = 5'b01000;
      wait_gnt("abort", 20);
      for (int k = 0; k < 40 && mon_hang_n < 10; k++) step(1);
      en = 1'b0;
      step(1);
      check("abort_hang_low", 32'(hang), 32'd0);
      check("abort_done", 32'(done), 32'd1);
      check("abort_hcnt", 32'(hcnt), 32'd1);
      check("abort_hang_cycles", 32'(mon_hang_n), 32'd10);
      clear_mon();
      step(20);
      check("abort_no_grant", 32'(mon_gnt_n), 32'd0);
      en = 1'b1;
      step(5);
      check("abort_regrant", 32'(mon_gnt_n), 32'd1);
      req = '0;

      // Async reset in the middle of a window.
      cfg(1, 0, 0, 0, 3); req = '0;
      do_reset(); clear_mon();
      req = 5'b00001;
      wait_gnt("ar_first", 20);
      req = 5'b10001;
      wait_gnt("ar_second", 20);
      check("ar_second_port", 32'(gnt), 32'b10000);
      set_len_all(20);
      step(2);
      check("ar_hang_before", 32'(hang), 32'b10000);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("ar_hang", 32'(hang), 32'd0);
      check("ar_gnt", 32'(gnt), 32'd0);
      check("ar_done", 32'(done), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_hcnt", 32'(hcnt), 32'd0);
      tick = 32'd10;
      step(3);
      rst_n = 1'b1;
      clear_mon();
      wait_gnt("ar_after", 40);
      check("ar_restart_gnt_cyc", 32'(first_gnt_cyc), 32'd12);
      check("ar_rr_reset", 32'(first_gnt_val), 32'b00001);
      req = '0;

      // Randomized traffic against the model.
      for (int seg = 0; seg < 4; seg++) begin
         cfg(1, $urandom_range(0, 40), $urandom_range(0, 4),
             (seg == 3) ? $urandom_range(1, 8) : ((seg == 2) ? 20 : 0), 0);
         req = '0;
         do_reset();
         for (int c = 0; c < 2500; c++) begin
            for (int p = 0; p < NPORT; p++) len_v[p*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) req = NPORT'($urandom);
            if (en && $urandom_range(0, 59) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 4) == 0) en = 1'b1;
            step(1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
